// File: rtl/spmp_pkg.sv
// Shared definitions for the SPMP CSR file: CSR address map, bank and
// access-kind enums, FSM states, cfg WARL mask and local stand-ins for
// the core's privilege-level and cfg-byte types.
package spmp_pkg;

  // CSR base addresses, hgSPMP bank.
  localparam logic [11:0] SPMP_SWITCH_HG = 12'h170;
  localparam logic [11:0] SPMP_CFG_HG    = 12'h1A0;
  localparam logic [11:0] SPMP_ADDR_HG   = 12'h1B0;

  // CSR base addresses, vSPMP bank (same layout one page up).
  localparam logic [11:0] SPMP_SWITCH_VS = 12'h270;
  localparam logic [11:0] SPMP_CFG_VS    = 12'h2A0;
  localparam logic [11:0] SPMP_ADDR_VS   = 12'h2B0;

  // Last spmpaddr CSR offset within a page (spmpaddr63).
  localparam logic [7:0] SPMP_ADDR_LAST_OFF = 8'hEF;

  // cfg bits [6:5] are reserved: always stored and read as 0.
  localparam logic [7:0] SPMPCFG_RSVD_MASK = 8'h60;

  // Privilege encoding as used by the core (HS is S with v_i = 0).
  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  // One SPMP entry configuration byte.
  typedef struct packed {
    logic       s_mode;
    logic [1:0] reserved;
    logic [1:0] addr_mode;
    logic [2:0] xwr;
  } spmpcfg_t;

  typedef enum logic {
    BANK_HG,
    BANK_VS
  } spmp_bank_e;

  typedef enum logic [1:0] {
    CSR_SWITCH,
    CSR_CFG,
    CSR_ADDR,
    CSR_NONE
  } csr_kind_e;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } flush_state_e;

  // Result of decoding one CSR request.
  typedef struct packed {
    logic       err;
    spmp_bank_e bank;
    csr_kind_e  kind;
    logic [5:0] idx;
  } csr_decode_t;

  // Bits of spmpswitch that correspond to implemented entries.
  function automatic logic [63:0] switch_mask(input int unsigned n_entries);
    if (n_entries >= 64) return '1;
    return (64'd1 << n_entries) - 64'd1;
  endfunction

endpackage

// File: rtl/spmp_csr_bank.sv
// One SPMP bank: cfg/addr/switch storage with WARL write handling and a
// combinational read mux. Reports whether the current write alters state.
module spmp_csr_bank
  import spmp_pkg::*;
#(
  parameter  int unsigned NrEntries = 8,
  parameter  int unsigned PLEN      = 56,
  localparam int unsigned N         = (NrEntries > 0) ? NrEntries : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  csr_kind_e                kind_i,
  input  logic [5:0]               idx_i,
  input  logic [63:0]              wdata_i,
  output logic [63:0]              rdata_o,
  output logic                     changed_o,
  output spmpcfg_t [N-1:0]         cfg_o,
  output logic [N-1:0][PLEN-3:0]   addr_o,
  output logic [63:0]              switch_o
);

  localparam logic [63:0] SwitchMask = switch_mask(NrEntries);

  spmpcfg_t [N-1:0]       cfg_q, cfg_d;
  logic [N-1:0][PLEN-3:0] addr_q, addr_d;
  logic [63:0]            switch_q, switch_d;

  // Next state: apply a write to implemented entries only, with WARL masking.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cfg_d    = cfg_q;
    addr_d   = addr_q;
    switch_d = switch_q;
    if (we_i) begin
      case (kind_i)
        CSR_SWITCH: switch_d = wdata_i & SwitchMask;
        CSR_CFG: begin
          for (int unsigned e = 0; e < N; e++) begin
            if (e < NrEntries && (e / 8) == 32'(idx_i[3:1])) begin
              cfg_d[e] = spmpcfg_t'(wdata_i[8*(e%8) +: 8] & ~SPMPCFG_RSVD_MASK);
            end
          end
        end
        CSR_ADDR: begin
          for (int unsigned e = 0; e < N; e++) begin
            if (e < NrEntries && e == 32'(idx_i)) begin
              addr_d[e] = wdata_i[PLEN-3:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign changed_o = (cfg_d != cfg_q) || (addr_d != addr_q) || (switch_d != switch_q);

  // Read mux: unimplemented entries are never written, so they read 0.
  always_comb begin
    rdata_o = '0;
    case (kind_i)
      CSR_SWITCH: rdata_o = switch_q;
      CSR_CFG: begin
        for (int unsigned e = 0; e < N; e++) begin
          if ((e / 8) == 32'(idx_i[3:1])) rdata_o[8*(e%8) +: 8] = cfg_q[e];
        end
      end
      CSR_ADDR: begin
        for (int unsigned e = 0; e < N; e++) begin
          if (e == 32'(idx_i)) rdata_o[PLEN-3:0] = addr_q[e];
        end
      end
      default: ;
    endcase
  end

  // Architectural storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: these small register arrays are architectural state with a defined reset value, so they are reset like any other flop.
    if (!rst_ni) begin
      cfg_q    <= '0;
      addr_q   <= '0;
      switch_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      cfg_q    <= cfg_d;
      addr_q   <= addr_d;
      switch_q <= switch_d;
    end
  end

  assign cfg_o    = cfg_q;
  assign addr_o   = addr_q;
  assign switch_o = switch_q;

endmodule

// File: rtl/spmp_csr_file.sv
// SPMP CSR file: decodes CSR requests, enforces privilege/bank steering,
// owns the hgSPMP and vSPMP banks and raises a flush on any state change,
// stalling further accesses until the flush is acknowledged.
module spmp_csr_file
  import spmp_pkg::*;
#(
  parameter  int unsigned NrSPMPEntries = 8,
  parameter  int unsigned PLEN          = 56,
  localparam int unsigned N             = (NrSPMPEntries > 0) ? NrSPMPEntries : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     csr_req_i,
  input  logic                     csr_we_i,
  input  logic [11:0]              csr_addr_i,
  input  logic [63:0]              csr_wdata_i,
  input  priv_lvl_t                priv_lvl_i,
  input  logic                     v_i,
  output logic                     csr_ready_o,
  output logic                     csr_valid_o,
  output logic [63:0]              csr_rdata_o,
  output logic                     csr_error_o,
  output spmpcfg_t [N-1:0]         spmpcfg_o,
  output logic [N-1:0][PLEN-3:0]   spmpaddr_o,
  output logic [63:0]              spmpswitch_o,
  output spmpcfg_t [N-1:0]         vspmpcfg_o,
  output logic [N-1:0][PLEN-3:0]   vspmpaddr_o,
  output logic [63:0]              vspmpswitch_o,
  output logic                     flush_o,
  input  logic                     flush_ack_i
);

  csr_decode_t  dec;
  logic [3:0]   page;
  logic [7:0]   off;
  logic         page_ok;
  spmp_bank_e   page_bank;

  flush_state_e state_q, state_d;
  logic         accept;
  logic         wr_hg, wr_vs;
  logic         hg_changed, vs_changed;
  logic [63:0]  hg_rdata, vs_rdata;

  logic         valid_q, error_q;
  logic [63:0]  rdata_q, rdata_d;

  assign page = csr_addr_i[11:8];
  assign off  = csr_addr_i[7:0];

  // Privilege check and bank steering: which bank a page maps to, if any.
  always_comb begin
    page_ok   = 1'b0;
    page_bank = BANK_HG;
    if (priv_lvl_i == PRIV_LVL_M || (priv_lvl_i == PRIV_LVL_S && !v_i)) begin
      if (page == SPMP_SWITCH_HG[11:8]) begin
        page_ok   = 1'b1;
        page_bank = BANK_HG;
      end else if (page == SPMP_SWITCH_VS[11:8]) begin
        page_ok   = 1'b1;
        page_bank = BANK_VS;
      end
    end else if (priv_lvl_i == PRIV_LVL_S && v_i) begin
      // A virtualized supervisor sees the vSPMP bank through the hg addresses.
      if (page == SPMP_SWITCH_HG[11:8]) begin
        page_ok   = 1'b1;
        page_bank = BANK_VS;
      end
    end
  end

  // Address decode within a page; both banks share the same offsets.
  always_comb begin
    dec.kind = CSR_NONE;
    dec.idx  = '0;
    if (off == SPMP_SWITCH_HG[7:0]) begin
      dec.kind = CSR_SWITCH;
    end else if (off[7:4] == SPMP_CFG_HG[7:4]) begin
      dec.kind = CSR_CFG;
      dec.idx  = {2'b00, off[3:0]};
    end else if (off >= SPMP_ADDR_HG[7:0] && off <= SPMP_ADDR_LAST_OFF) begin
      dec.kind = CSR_ADDR;
      dec.idx  = off[5:0] - SPMP_ADDR_HG[5:0];
    end
    dec.bank = page_bank;
    dec.err  = !page_ok || (dec.kind == CSR_NONE) || (dec.kind == CSR_CFG && off[0]);
  end

  assign csr_ready_o = (state_q == ST_IDLE);
  assign accept      = csr_req_i && csr_ready_o;
  assign wr_hg       = accept && csr_we_i && !dec.err && (dec.bank == BANK_HG);
  assign wr_vs       = accept && csr_we_i && !dec.err && (dec.bank == BANK_VS);

  spmp_csr_bank #(
    .NrEntries(NrSPMPEntries),
    .PLEN     (PLEN)
  ) u_bank_hg (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (wr_hg),
    .kind_i   (dec.kind),
    .idx_i    (dec.idx),
    .wdata_i  (csr_wdata_i),
    .rdata_o  (hg_rdata),
    .changed_o(hg_changed),
    .cfg_o    (spmpcfg_o),
    .addr_o   (spmpaddr_o),
    .switch_o (spmpswitch_o)
  );

  spmp_csr_bank #(
    .NrEntries(NrSPMPEntries),
    .PLEN     (PLEN)
  ) u_bank_vs (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (wr_vs),
    .kind_i   (dec.kind),
    .idx_i    (dec.idx),
    .wdata_i  (csr_wdata_i),
    .rdata_o  (vs_rdata),
    .changed_o(vs_changed),
    .cfg_o    (vspmpcfg_o),
    .addr_o   (vspmpaddr_o),
    .switch_o (vspmpswitch_o)
  );

  // Flush FSM next state: a state-changing write opens a flush, the ack closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hg_changed || vs_changed) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_ack_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Flush FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  assign flush_o = (NrSPMPEntries != 0) && (state_q == ST_FLUSH);

  // Read data returned only for legal reads; writes and errors return 0.
  always_comb begin
    rdata_d = '0;
    if (accept && !csr_we_i && !dec.err) begin
      rdata_d = (dec.bank == BANK_HG) ? hg_rdata : vs_rdata;
    end
  end

  // Response register: one-cycle valid pulse after each accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= accept;
      error_q <= accept && dec.err;
      rdata_q <= rdata_d;
    end
  end

  assign csr_valid_o = valid_q;
  assign csr_error_o = error_q;
  assign csr_rdata_o = rdata_q;

endmodule
